audio_prefetch_ctrl: RTL and testbench
======================================

# audio_prefetch_ctrl

Sequences 16-bit audio sample reads from SDRAM through the shared bridge-style port (read / acknowledge / read_data) into a small FIFO, and supplies one sample per I2S request. It sits between the I2S serializer and the SDRAM arbiter. Its job is to keep SDRAM traffic bursty and to decouple I2S timing from arbitration latency. It has one outstanding read at a time, refills by watermark, optionally loops a buffer, and flags underrun.

## Interface
- FIFO_DEPTH, 16: sample FIFO entries; power of two, ≥4.
- LOW_WATER, 8: refill starts when FIFO count ≤ LOW_WATER; must be < FIFO_DEPTH.
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: latch base_addr/length/loop and begin; ignored while busy.
- stop  in  1  one-cycle pulse: abort stream; ignored while idle.
- base_addr  in  25  first word address.
- length  in  25  number of 16-bit words in buffer.
- loop  in  1  1 = wrap to base_addr at end of buffer, never finish.
- bus_read  out  1  read request to SDRAM arbiter.
- bus_addr  out  25  word address, stable while bus_read=1.
- bus_ac  in  1  acknowledge; bus_rddata valid in same cycle.
- bus_rddata  in  16  read data.
- sample_req  in  1  one-cycle pulse from I2S: next sample wanted.
- sample_data  out  16  sample presented with sample_valid.
- sample_valid  out  1  one-cycle pulse.
- busy  out  1  stream active (from start accept until IDLE).
- done  out  1  one-cycle pulse on normal completion.
- underrun  out  1  sticky; set when a request hits an empty FIFO while busy; cleared by start.

## Operation
- States: IDLE, ISSUE, GAP, HOLD, DRAIN, ABORT.
- IDLE: on start, latch base/length/loop and set addr=base, remaining=length. Clear underrun and flush the FIFO. If length=0, pulse done and stay IDLE. Otherwise go to ISSUE with busy=1.
- ISSUE: bus_read=1, bus_addr=addr. Hold until bus_ac. On bus_ac:
  - push bus_rddata, addr+1, remaining−1;
  - go to GAP.
- GAP: bus_read=0 for exactly one cycle. Then:
  - remaining=0 and loop=1: addr←base, remaining←length; treat as remaining>0 below.
  - remaining=0 and loop=0: go to DRAIN.
  - count<FIFO_DEPTH: go to ISSUE.
  - otherwise: go to HOLD.
- HOLD: wait until count ≤ LOW_WATER, then go to ISSUE.
- DRAIN: no reads. When FIFO is empty, pulse done, busy←0, go to IDLE.
- stop in ISSUE: go to ABORT. Keep bus_read/bus_addr until bus_ac, discard the data, then flush and go to IDLE. No done pulse.
- stop in GAP/HOLD/DRAIN: flush, go to IDLE next cycle.
- Sample side (independent of FSM):
  - sample_req with count>0: sample_data←head, pop.
  - sample_req with count=0: sample_data←0; set underrun if busy.
  - sample_valid pulses on every accepted sample_req.
- Simultaneous push and pop: count unchanged, ordering preserved (pop returns the older head). Overflow is impossible: one outstanding read, issued only when count<FIFO_DEPTH.
- addr arithmetic is 25-bit and wraps modulo 2^25 silently.

## Timing
- Reset values: bus_read 0, bus_addr 0, sample_data 0, sample_valid 0, busy 0, done 0, underrun 0, FSM IDLE, FIFO empty.
- start sampled at edge k: busy=1 and bus_read=1 after edge k.
- bus_ac at edge n: push visible (count+1) after edge n. bus_read=0 for cycle n+1, reasserted after edge n+1 earliest. Minimum 2 cycles per word.
- sample_req at edge k: sample_valid=1 and sample_data valid for one cycle after edge k.
- done: one cycle, after the edge where DRAIN sees count=0; busy falls on the same edge.
- start coincident with done: ignored.
- start while busy: ignored.
- stop and start in the same cycle while IDLE: start wins.

## Test plan
- base=0x100, length=4, loop=0, bus_ac 3 cycles after each read, no sample_req. Expect reads at 0x100–0x103, one GAP cycle each, then DRAIN holds with count=4. After 4 sample_req, expect data in order, then done pulse; busy falls.
- length=40, FIFO_DEPTH=16, no sample_req. Expect exactly 16 reads, then HOLD. Issue 8 sample_req (count 8): expect ISSUE re-entered at address base+16.
- loop=1, length=3, base=0x10, continuous sample_req every 4 cycles with bus_ac immediate. Expect address sequence 0x10,0x11,0x12,0x10,…, no done, underrun stays 0.
- sample_req while FIFO empty and busy (bus_ac withheld): expect sample_data=0, sample_valid pulse, underrun=1 until next start.
- stop during ISSUE with bus_ac delayed 5 cycles: expect bus_read held until ac, data discarded, busy=0 the cycle after ac, no done. Assert reset_n low mid-ISSUE: all outputs return to reset values immediately.
- start with length=0: expect done pulse one cycle later, zero bus_read cycles, busy stays 0.

Source files
------------

// File: rtl/audio_prefetch_ctrl.sv
// rtl/audio_prefetch_ctrl.sv - SDRAM-to-I2S audio sample prefetcher with watermark refill
module audio_prefetch_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [24:0] base_addr,
    input  logic [24:0] length,
    input  logic        loop,
    output logic        bus_read,
    output logic [24:0] bus_addr,
    input  logic        bus_ac,
    input  logic [15:0] bus_rddata,
    input  logic        sample_req,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    output logic        busy,
    output logic        done,
    output logic        underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LOW_C   = CW'(LOW_WATER);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_GAP, S_HOLD, S_DRAIN, S_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [24:0]   base_q, len_q, addr_q, rem_q;
    logic          loop_q;
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop, flush, load, reload, done_set, start_ok;

    // A start landing on the done cycle is treated as part of the finishing stream.
    assign start_ok = (state_q == S_IDLE) && start && !done;
    assign pop      = sample_req && (count != '0);
    assign bus_read = (state_q == S_ISSUE) || (state_q == S_ABORT);
    assign bus_addr = addr_q;
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        flush    = 1'b0;
        load     = 1'b0;
        reload   = 1'b0;
        done_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    load  = 1'b1;
                    flush = 1'b1;
                    if (length == '0) done_set = 1'b1;
                    else              state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A stop that coincides with the acknowledge needs no abort wait.
                if (stop) begin
                    if (bus_ac) begin
                        flush   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ABORT;
                    end
                end else if (bus_ac) begin
                    push    = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (stop) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (rem_q == '0 && !loop_q) begin
                    state_d = S_DRAIN;
                end else begin
                    reload  = (rem_q == '0);
                    state_d = (count < DEPTH_C) ? S_ISSUE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (stop) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (count <= LOW_C) begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (stop) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (count == '0) begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_ABORT: begin
                if (bus_ac) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_set;
            if (load) begin
                base_q <= base_addr;
                len_q  <= length;
                loop_q <= loop;
                addr_q <= base_addr;
                rem_q  <= length;
            end else if (push) begin
                addr_q <= addr_q + 25'd1;
                rem_q  <= rem_q - 25'd1;
            end else if (reload) begin
                addr_q <= base_q;
                rem_q  <= len_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus_rddata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sample side runs regardless of FSM state; an empty FIFO answers with silence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sample_valid <= sample_req;
            if (sample_req) sample_data <= pop ? fifo_mem[rd_ptr] : 16'h0000;
            if (start_ok) underrun <= 1'b0;
            else if (sample_req && count == '0 && busy) underrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_audio_prefetch_ctrl.sv
// tb/tb_audio_prefetch_ctrl.sv - randomized self-checking bench for audio_prefetch_ctrl
module tb_audio_prefetch_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [24:0] base_addr = '0, length = '0;
    logic        bus_read, bus_ac = 1'b0;
    logic [24:0] bus_addr;
    logic [15:0] bus_rddata = '0;
    logic        sample_req = 1'b0;
    logic [15:0] sample_data;
    logic        sample_valid, busy, done, underrun;

    int checks = 0, errors = 0;

    bit          resp_en = 1'b1, rand_delay = 1'b0, ack_now = 1'b0, prev_ack = 1'b0;
    int          ac_delay = 0, wait_cnt = 0, ack_cnt = 0, rd_cycles = 0, gap_err = 0, done_cnt = 0;
    logic [24:0] addr_log[$];
    logic [24:0] m_base = '0;
    int          m_len = 1, m_pops = 0;

    audio_prefetch_ctrl #(.FIFO_DEPTH(16), .LOW_WATER(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .base_addr(base_addr), .length(length), .loop(loop),
        .bus_read(bus_read), .bus_addr(bus_addr), .bus_ac(bus_ac), .bus_rddata(bus_rddata),
        .sample_req(sample_req), .sample_data(sample_data), .sample_valid(sample_valid),
        .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [24:0] a);
        return a[15:0] ^ {a[24:16], 7'h5B} ^ 16'hC3A5;
    endfunction

    // SDRAM responder: acts 2 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            prev_ack = bus_ac;
            bus_ac   = 1'b0;
            ack_now  = 1'b0;
            if (done) done_cnt++;
            if (prev_ack && bus_read) gap_err++;
            if (bus_read) begin
                rd_cycles++;
                if (resp_en && wait_cnt >= ac_delay) begin
                    bus_ac     = 1'b1;
                    ack_now    = 1'b1;
                    ack_cnt++;
                    bus_rddata = mem_word(bus_addr);
                    addr_log.push_back(bus_addr);
                    wait_cnt   = 0;
                    if (rand_delay) ac_delay = $urandom_range(0, 4);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic clear_model;
        ack_cnt = 0; m_pops = 0; rd_cycles = 0; gap_err = 0;
        addr_log.delete();
    endtask

    task automatic pulse_start(input logic [24:0] b, input logic [24:0] l, input logic lp);
        @(negedge clk);
        base_addr = b; length = l; loop = lp; start = 1'b1;
        m_base = b; m_len = (l == '0) ? 1 : int'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Model: k-th delivered sample is word (k mod length) of the buffer, if it has arrived.
    task automatic do_req(output logic v, output logic [15:0] d, output logic [15:0] e);
        int avail;
        avail = ack_cnt - (ack_now ? 1 : 0) - m_pops;
        if (avail > 0) begin
            e = mem_word(m_base + 25'(m_pops % m_len));
            m_pops++;
        end else begin
            e = 16'h0000;
        end
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        v = sample_valid;
        d = sample_data;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus_read !== 1'b0) begin errors++; $display("FAIL reset_bus_read: got %b want 0", bus_read); end
        checks++; if (bus_addr !== 25'h0) begin errors++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
        checks++; if (sample_data !== 16'h0) begin errors++; $display("FAIL reset_sample_data: got %h want 0", sample_data); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid: got %b want 0", sample_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || bus_read !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b read=%b want 0/0", busy, bus_read); end
    endtask

    task automatic test_basic;
        logic v; logic [15:0] d, e; bit seen; int d0;
        clear_model; ac_delay = 3; rand_delay = 1'b0; resp_en = 1'b1; d0 = done_cnt;
        pulse_start(25'h100, 25'd4, 1'b0);
        checks++; if (busy !== 1'b1 || bus_read !== 1'b1) begin errors++; $display("FAIL basic_start: got busy=%b read=%b want 1/1", busy, bus_read); end
        checks++; if (bus_addr !== 25'h100) begin errors++; $display("FAIL basic_first_addr: got %h want 100", bus_addr); end
        base_addr = 25'h900; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ack_cnt >= 4 && !ack_now) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks++; if (addr_log.size() != 4) begin errors++; $display("FAIL basic_read_count: got %0d want 4", addr_log.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_log[i] !== 25'h100 + 25'(i)) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", i, addr_log[i], 25'h100 + 25'(i)); end
        end
        checks++; if (rd_cycles != 4 * (3 + 1)) begin errors++; $display("FAIL basic_read_cycles: got %0d want %0d", rd_cycles, 16); end
        checks++; if (gap_err != 0) begin errors++; $display("FAIL basic_gap: got %0d back-to-back reads want 0", gap_err); end
        checks++; if (busy !== 1'b1 || bus_read !== 1'b0 || done_cnt != d0) begin errors++; $display("FAIL basic_drain_hold: got busy=%b read=%b dones=%0d want 1/0/%0d", busy, bus_read, done_cnt, d0); end
        for (int i = 0; i < 4; i++) begin
            do_req(v, d, e);
            checks++;
            if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL basic_sample%0d: got v=%b d=%h want 1/%h", i, v, d, e); end
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen || busy !== 1'b0) begin errors++; $display("FAIL basic_done: got seen=%b busy=%b want 1/0", seen, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done); end
    endtask

    task automatic test_hold;
        logic v; logic [15:0] d, e; bit seen, ok; int d0;
        clear_model; ac_delay = 0; rand_delay = 1'b0; resp_en = 1'b1; d0 = done_cnt;
        pulse_start(25'h2000, 25'd40, 1'b0);
        repeat (45) @(negedge clk);
        checks++; if (ack_cnt != 16 || bus_read !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL hold_fill: got reads=%0d read=%b busy=%b want 16/0/1", ack_cnt, bus_read, busy); end
        for (int i = 0; i < 7; i++) begin
            do_req(v, d, e);
            checks++;
            if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL hold_sample%0d: got v=%b d=%h want 1/%h", i, v, d, e); end
        end
        repeat (4) @(negedge clk);
        checks++; if (ack_cnt != 16 || bus_read !== 1'b0) begin errors++; $display("FAIL hold_above_water: got reads=%0d read=%b want 16/0", ack_cnt, bus_read); end
        do_req(v, d, e);
        checks++; if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL hold_sample7: got v=%b d=%h want 1/%h", v, d, e); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus_read === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen || bus_addr !== 25'h2010) begin errors++; $display("FAIL hold_refill: got seen=%b addr=%h want 1/2010", seen, bus_addr); end
        pulse_stop;
        wait_idle(30, ok);
        checks++; if (!ok || done_cnt != d0) begin errors++; $display("FAIL hold_stop: got idle=%b dones=%0d want 1/%0d", ok, done_cnt, d0); end
    endtask

    task automatic test_loop;
        logic v; logic [15:0] d, e; bit ok; int d0, bad;
        clear_model; ac_delay = 0; rand_delay = 1'b0; resp_en = 1'b1; d0 = done_cnt;
        pulse_start(25'h10, 25'd3, 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            do_req(v, d, e);
            checks++;
            if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL loop_sample%0d: got v=%b d=%h want 1/%h", i, v, d, e); end
            repeat (3) @(negedge clk);
        end
        bad = 0;
        for (int i = 0; i < 12; i++) if (addr_log[i] !== 25'h10 + 25'(i % 3)) bad++;
        checks++; if (addr_log.size() < 12 || bad != 0) begin errors++; $display("FAIL loop_addrs: got %0d reads with %0d wrong want >=12 with 0", addr_log.size(), bad); end
        checks++; if (underrun !== 1'b0 || done_cnt != d0 || busy !== 1'b1) begin errors++; $display("FAIL loop_state: got underrun=%b dones=%0d busy=%b want 0/%0d/1", underrun, done_cnt, busy, d0); end
        pulse_stop;
        wait_idle(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL loop_stop: got busy=%b want 0", busy); end
    endtask

    task automatic test_underrun;
        logic v; logic [15:0] d, e; bit ok;
        clear_model; resp_en = 1'b0; ac_delay = 0; rand_delay = 1'b0;
        pulse_start(25'h4000, 25'd5, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_before: got %b want 0", underrun); end
        do_req(v, d, e);
        checks++; if (v !== 1'b1 || d !== 16'h0000 || d !== e) begin errors++; $display("FAIL underrun_sample: got v=%b d=%h want 1/0", v, d); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b want 1", underrun); end
        repeat (3) @(negedge clk);
        pulse_stop;
        resp_en = 1'b1;
        wait_idle(20, ok);
        checks++; if (!ok || underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got idle=%b underrun=%b want 1/1", ok, underrun); end
        repeat (2) @(negedge clk);
        pulse_start(25'h4000, 25'd0, 1'b0);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b want 0", underrun); end
    endtask

    task automatic test_stop_abort;
        logic v; logic [15:0] d, e; bit got; int d0, hold_bad;
        clear_model; ac_delay = 5; rand_delay = 1'b0; resp_en = 1'b1; d0 = done_cnt;
        pulse_start(25'h300, 25'd10, 1'b0);
        pulse_stop;
        hold_bad = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_read !== 1'b1 || bus_addr !== 25'h300) hold_bad++;
            if (ack_now) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!got || hold_bad != 0) begin errors++; $display("FAIL abort_hold: got acked=%b bad_cycles=%0d want 1/0", got, hold_bad); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus_read !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b read=%b want 0/0", busy, bus_read); end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt != d0 || ack_cnt != 1) begin errors++; $display("FAIL abort_no_done: got dones=%0d reads=%0d want %0d/1", done_cnt, ack_cnt, d0); end
        clear_model;
        do_req(v, d, e);
        checks++; if (v !== 1'b1 || d !== 16'h0000 || underrun !== 1'b0) begin errors++; $display("FAIL abort_discard: got v=%b d=%h underrun=%b want 1/0/0", v, d, underrun); end

        clear_model; ac_delay = 5;
        pulse_start(25'h1ABCDE, 25'd4, 1'b0);
        @(negedge clk);
        checks++; if (bus_read !== 1'b1 || bus_addr !== 25'h1ABCDE) begin errors++; $display("FAIL rst_pre: got read=%b addr=%h want 1/1abcde", bus_read, bus_addr); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus_read !== 1'b0 || bus_addr !== 25'h0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async_bus: got read=%b addr=%h busy=%b want 0/0/0", bus_read, bus_addr, busy); end
        checks++; if (sample_valid !== 1'b0 || sample_data !== 16'h0 || done !== 1'b0 || underrun !== 1'b0) begin errors++; $display("FAIL rst_async_side: got v=%b d=%h done=%b ur=%b want 0/0/0/0", sample_valid, sample_data, done, underrun); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_len;
        bit ok; int d0;
        clear_model; ac_delay = 0; rand_delay = 1'b0; resp_en = 1'b1; d0 = done_cnt;
        pulse_start(25'h500, 25'd0, 1'b0);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || bus_read !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b busy=%b read=%b want 1/0/0", done, busy, bus_read); end
        base_addr = 25'h510; length = 25'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL start_on_done: got busy=%b done=%b want 0/0", busy, done); end
        repeat (3) @(negedge clk);
        checks++; if (rd_cycles != 0 || done_cnt != d0 + 1) begin errors++; $display("FAIL zero_reads: got cycles=%0d dones=%0d want 0/%0d", rd_cycles, done_cnt, d0 + 1); end
        base_addr = 25'h600; length = 25'd2; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        checks++; if (busy !== 1'b1 || bus_read !== 1'b1 || bus_addr !== 25'h600) begin errors++; $display("FAIL start_beats_stop: got busy=%b read=%b addr=%h want 1/1/600", busy, bus_read, bus_addr); end
        pulse_stop;
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_cleanup: got busy=%b want 0", busy); end
    endtask

    task automatic test_random;
        logic v; logic [15:0] d, e; bit ok; int d0, bad, len; logic [24:0] b; logic lp;
        for (int it = 0; it < 6; it++) begin
            clear_model; resp_en = 1'b1; rand_delay = 1'b1; ac_delay = $urandom_range(0, 4);
            b   = (it % 2 == 0) ? 25'h1FFFFFF - 25'($urandom_range(0, 6)) : 25'($urandom);
            len = $urandom_range(1, 24);
            lp  = 1'($urandom_range(0, 1));
            d0  = done_cnt;
            pulse_start(b, 25'(len), lp);
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    do_req(v, d, e);
                    checks++;
                    if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL rand%0d_sample%0d: got v=%b d=%h want 1/%h", it, m_pops, v, d, e); end
                end else begin
                    @(negedge clk);
                end
            end
            if (!lp) begin
                for (int c = 0; c < 400 && m_pops < len; c++) begin
                    do_req(v, d, e);
                    checks++;
                    if (v !== 1'b1 || d !== e) begin errors++; $display("FAIL rand%0d_drain%0d: got v=%b d=%h want 1/%h", it, m_pops, v, d, e); end
                end
                for (int c = 0; c < 20 && done_cnt == d0; c++) @(negedge clk);
                checks++; if (done_cnt != d0 + 1 || ack_cnt != len || busy !== 1'b0) begin errors++; $display("FAIL rand%0d_finish: got dones=%0d reads=%0d busy=%b want %0d/%0d/0", it, done_cnt - d0, ack_cnt, busy, 1, len); end
            end else begin
                pulse_stop;
                wait_idle(30, ok);
                checks++; if (!ok || done_cnt != d0) begin errors++; $display("FAIL rand%0d_loop_stop: got idle=%b dones=%0d want 1/%0d", it, ok, done_cnt - d0, 0); end
            end
            bad = 0;
            foreach (addr_log[i]) if (addr_log[i] !== b + 25'(i % len)) bad++;
            checks++; if (bad != 0 || gap_err != 0) begin errors++; $display("FAIL rand%0d_addrs: got %0d wrong addrs %0d gap errors want 0/0", it, bad, gap_err); end
            repeat (2) @(negedge clk);
        end
        rand_delay = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_loop;
        test_underrun;
        test_stop_abort;
        test_zero_len;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
